// File: rtl/datapath_if.sv
// datapath_if: control strobes, memory data and observed bus of the single-bus datapath
interface datapath_if #(parameter int WIDTH = 32);
    logic PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
    logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Cin;
    logic [4:0] AND;
    logic R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
    logic R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic HIin, LOin, ZHighIn, ZLowIn;
    logic [WIDTH-1:0] Mdatain;
    logic [WIDTH-1:0] BusMuxOut;
    modport master (
        output PCout, ZHighout, Zlowout, MDRout, R2out, R4out,
        output MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Cin, AND,
        output R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in,
        output R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        output HIin, LOin, ZHighIn, ZLowIn, Mdatain,
        input BusMuxOut
    );
    modport slave (
        input PCout, ZHighout, Zlowout, MDRout, R2out, R4out,
        input MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Cin, AND,
        input R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in,
        input R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        input HIin, LOin, ZHighIn, ZLowIn, Mdatain,
        output BusMuxOut
    );
endinterface

// File: rtl/datapath.sv
// datapath: single-bus multi-cycle CPU datapath with register file, PC/IR/MAR/MDR/Y/Z/HI/LO and ALU
module datapath #(parameter int WIDTH = 32) (
    input logic Clock,
    input logic Clear,
    datapath_if.slave d
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] r [16];
    logic [WIDTH-1:0] pc, ir, mar, mdr, y, hi, lo, z_hi, z_lo, bus, dif;
    logic [WIDTH:0] sum;
    logic [2*WIDTH-1:0] alu;
    logic [15:1] rin;
    assign rin = {d.R15in, d.R14in, d.R13in, d.R12in, d.R11in, d.R10in, d.R9in, d.R8in,
                  d.R7in, d.R6in, d.R5in, d.R4in, d.R3in, d.R2in, d.R1in};
    assign bus = d.Zlowout ? z_lo : d.ZHighout ? z_hi : d.MDRout ? mdr :
                 d.R4out ? r[4] : d.R2out ? r[2] : d.PCout ? pc : '0;
    assign d.BusMuxOut = bus;
    assign sum = {1'b0, y} + {1'b0, bus} + (WIDTH+1)'(d.Cin);
    assign dif = y - bus;
    always_comb begin
        alu = '0;
        if (d.IncPC)
            alu = {{WIDTH{1'b0}}, bus + WIDTH'(1)};
        else
            case (d.AND)
                5'b00011: alu = {{(WIDTH-1){1'b0}}, sum};
                5'b00100: alu = {{WIDTH{dif[WIDTH-1]}}, dif};
                5'b00101: alu = {{WIDTH{1'b0}}, y >> bus[SW-1:0]};
                5'b00110: alu = {{WIDTH{1'b0}}, y << bus[SW-1:0]};
                5'b01001: alu = {{WIDTH{1'b0}}, y & bus};
                5'b01010: alu = {{WIDTH{1'b0}}, y | bus};
                5'b10000: alu = {{WIDTH{1'b0}}, -bus};
                5'b10001: alu = {{WIDTH{1'b0}}, ~bus};
                default:  alu = '0;
            endcase
    end
    // R0 is never written after reset, so it stays zero
    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc <= '0;
            ir <= '0;
            mar <= '0;
            mdr <= '0;
            y <= '0;
            hi <= '0;
            lo <= '0;
            z_hi <= '0;
            z_lo <= '0;
            for (int i = 0; i < 16; i++) r[i] <= '0;
        end else begin
            pc <= d.PCin ? bus : pc;
            ir <= d.IRin ? bus : ir;
            mar <= d.MARin ? bus : mar;
            mdr <= d.MDRin ? (d.Read ? d.Mdatain : bus) : mdr;
            y <= d.Yin ? bus : y;
            hi <= d.HIin ? bus : hi;
            lo <= d.LOin ? bus : lo;
            z_hi <= d.ZHighIn ? alu[2*WIDTH-1:WIDTH] : z_hi;
            z_lo <= d.ZLowIn ? alu[WIDTH-1:0] : z_lo;
            for (int i = 1; i < 16; i++) r[i] <= rin[i] ? bus : r[i];
        end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vectors with hand-computed expectations for the single-bus datapath
module tb_datapath;
    logic Clock = 0;
    logic Clear;
    int n_checks = 0;
    int n_fails = 0;
    datapath_if d ();
    datapath dut (.Clock(Clock), .Clear(Clear), .d(d));
    always #5 Clock = ~Clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic idle();
        {d.PCout, d.ZHighout, d.Zlowout, d.MDRout, d.R2out, d.R4out} = '0;
        {d.MARin, d.PCin, d.MDRin, d.IRin, d.Yin, d.IncPC, d.Read, d.Cin} = '0;
        {d.R1in, d.R2in, d.R3in, d.R4in, d.R5in, d.R6in, d.R7in, d.R8in} = '0;
        {d.R9in, d.R10in, d.R11in, d.R12in, d.R13in, d.R14in, d.R15in} = '0;
        {d.HIin, d.LOin, d.ZHighIn, d.ZLowIn} = '0;
        d.AND = 5'b0;
    endtask
    task automatic step();
        @(posedge Clock);
        #1;
    endtask
    task automatic load_mdr(input logic [31:0] v);
        d.Mdatain = v; d.Read = 1; d.MDRin = 1;
        step(); idle();
    endtask
    task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic c, input logic inc);
        load_mdr(a);
        d.MDRout = 1; d.Yin = 1;
        step(); idle();
        load_mdr(b);
        d.MDRout = 1; d.AND = op; d.Cin = c; d.IncPC = inc; d.ZLowIn = 1; d.ZHighIn = 1;
        step(); idle();
    endtask
    task automatic check_z(input string tag, input logic [31:0] lo, input logic [31:0] hi);
        d.Zlowout = 1; #1;
        check({tag, "_lo"}, d.BusMuxOut, lo);
        d.Zlowout = 0; d.ZHighout = 1; #1;
        check({tag, "_hi"}, d.BusMuxOut, hi);
        idle();
    endtask
    initial begin
        idle();
        d.Mdatain = '0;
        Clear = 1;
        step();
        Clear = 0;
        check("reset_bus", d.BusMuxOut, 32'h0);
        d.PCout = 1; #1;
        check("reset_pc", d.BusMuxOut, 32'h0);
        d.PCout = 0; d.MDRout = 1; #1;
        check("reset_mdr", d.BusMuxOut, 32'h0);
        idle();
        check_z("reset_z", 32'h0, 32'h0);
        // R2 = 0x22, R4 = 0x24 via MDR
        load_mdr(32'h22);
        d.MDRout = 1; d.R2in = 1; #1;
        check("mdr_22", d.BusMuxOut, 32'h22);
        step(); idle();
        d.R2out = 1; #1;
        check("r2", d.BusMuxOut, 32'h22);
        idle();
        load_mdr(32'h24);
        d.MDRout = 1; d.R4in = 1;
        step(); idle();
        d.R4out = 1; #1;
        check("r4", d.BusMuxOut, 32'h24);
        idle();
        d.R2out = 1; d.Yin = 1;
        step(); idle();
        d.R4out = 1; d.AND = 5'b01001; d.ZLowIn = 1;
        step(); idle();
        d.Zlowout = 1; d.R5in = 1; #1;
        check("and_bus", d.BusMuxOut, 32'h20);
        step(); idle();
        check("r5", dut.r[5], 32'h20);
        check("r0", dut.r[0], 32'h0);
        // instruction fetch
        d.PCout = 1; d.MARin = 1; d.IncPC = 1; d.ZLowIn = 1;
        step(); idle();
        check("mar", dut.mar, 32'h0);
        d.Zlowout = 1; #1;
        check("incpc", d.BusMuxOut, 32'h1);
        d.PCin = 1;
        step(); idle();
        d.PCout = 1; #1;
        check("pc", d.BusMuxOut, 32'h1);
        idle();
        load_mdr(32'h4A920000);
        d.MDRout = 1; d.IRin = 1;
        step(); idle();
        check("ir", dut.ir, 32'h4A920000);
        // ALU vectors
        alu(32'hFFFFFFFF, 32'h1, 5'b00011, 1'b0, 1'b0);
        check_z("add_c0", 32'h0, 32'h1);
        alu(32'hFFFFFFFF, 32'h1, 5'b00011, 1'b1, 1'b0);
        check_z("add_c1", 32'h1, 32'h1);
        alu(32'h1, 32'h2, 5'b00100, 1'b0, 1'b0);
        check_z("sub_neg", 32'hFFFFFFFF, 32'hFFFFFFFF);
        alu(32'h5, 32'h3, 5'b00100, 1'b0, 1'b0);
        check_z("sub_pos", 32'h2, 32'h0);
        alu(32'h80000000, 32'h21, 5'b00101, 1'b0, 1'b0);
        check_z("shr", 32'h40000000, 32'h0);
        alu(32'h1, 32'h1F, 5'b00110, 1'b0, 1'b0);
        check_z("shl", 32'h80000000, 32'h0);
        alu(32'hF0, 32'h0F, 5'b01010, 1'b0, 1'b0);
        check_z("or", 32'hFF, 32'h0);
        alu(32'h0, 32'h1, 5'b10000, 1'b0, 1'b0);
        check_z("neg", 32'hFFFFFFFF, 32'h0);
        alu(32'h0, 32'h0, 5'b10001, 1'b0, 1'b0);
        check_z("not", 32'hFFFFFFFF, 32'h0);
        alu(32'h7, 32'h9, 5'b00000, 1'b0, 1'b0);
        check_z("bad_op", 32'h0, 32'h0);
        alu(32'h7, 32'hFFFFFFFF, 5'b00011, 1'b1, 1'b1);
        check_z("incpc_ovr", 32'h0, 32'h0);
        // priority: Z low beats MDR
        alu(32'h3, 32'h4, 5'b00011, 1'b0, 1'b0);
        load_mdr(32'hABCD);
        d.Zlowout = 1; d.MDRout = 1; #1;
        check("prio", d.BusMuxOut, 32'h7);
        idle();
        // self-load holds value
        d.MDRout = 1; d.MDRin = 1;
        step(); idle();
        d.MDRout = 1; #1;
        check("mdr_self", d.BusMuxOut, 32'hABCD);
        idle();
        // Clear beats in strobes
        d.Mdatain = 32'h55; d.Read = 1; d.MDRin = 1; Clear = 1;
        step(); idle(); Clear = 0;
        d.MDRout = 1; #1;
        check("clr_mdr", d.BusMuxOut, 32'h0);
        idle();
        d.PCout = 1; #1;
        check("clr_pc", d.BusMuxOut, 32'h0);
        idle();
        check("clr_r5", dut.r[5], 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
